// File: rtl/root500_child_dispatcher.sv
// root500_child_dispatcher: FIFO-buffered round-robin dispatcher that offers each word to one enabled child.
module root500_child_dispatcher #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  localparam int SW = $clog2(NUM_CHILD),
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NUM_CHILD-1:0] child_en,
  output logic [NUM_CHILD-1:0] out_valid,
  input  logic [NUM_CHILD-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [SW-1:0]        out_sel,
  output logic [CW-1:0]        fifo_count,
  output logic [15:0]          dispatch_cnt
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_ptr;
  logic              r_offering;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_dcnt;
  logic              w_push, w_accept, w_start, w_skip, w_found;
  logic [SW-1:0]     w_nxt, w_inc, w_ptr_nxt;
  logic [DATA_W-1:0] w_head;

  function automatic logic [SW-1:0] wrap(input int v);
    return SW'(v % NUM_CHILD);
  endfunction

  assign in_ready     = rst_n & (r_count < CW'(DEPTH));
  assign w_push       = in_valid & in_ready;
  assign w_accept     = r_offering & out_ready[r_ptr];
  // An empty FIFO forwards the incoming word so it can be offered the very next cycle.
  assign w_head       = (r_count != '0) ? r_mem[r_rp] : in_data;
  assign w_start      = !r_offering & ((r_count != '0) | w_push) & child_en[r_ptr];
  assign w_skip       = !r_offering & !child_en[r_ptr];
  assign w_inc        = (r_ptr == SW'(NUM_CHILD - 1)) ? '0 : r_ptr + 1'b1;
  assign w_ptr_nxt    = w_accept ? (w_found ? w_nxt : w_inc) : (w_skip & w_found) ? w_nxt : r_ptr;
  assign out_valid    = r_offering ? (NUM_CHILD'(1) << r_ptr) : '0;
  assign out_data     = r_data;
  assign out_sel      = r_ptr;
  assign fifo_count   = r_count;
  assign dispatch_cnt = r_dcnt;

  // Nearest enabled child after the pointer; descending loop lets the closest one win.
  always_comb begin
    w_found = 1'b0;
    w_nxt   = r_ptr;
    for (int k = NUM_CHILD - 1; k >= 1; k--)
      if (child_en[wrap(int'(r_ptr) + k)]) begin
        w_found = 1'b1;
        w_nxt   = wrap(int'(r_ptr) + k);
      end
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_ptr      <= '0;
      r_offering <= 1'b0;
      r_data     <= '0;
      r_dcnt     <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_accept) begin
        r_rp   <= r_rp + 1'b1;
        r_dcnt <= r_dcnt + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_accept);
      if (w_start) begin
        r_offering <= 1'b1;
        r_data     <= w_head;
      end else if (w_accept) r_offering <= 1'b0;
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: tb/tb_root500_child_dispatcher.sv
// tb_root500_child_dispatcher: scoreboard bench for the round-robin child dispatcher.
module tb_root500_child_dispatcher;
  typedef struct {int ch; logic [31:0] d;} exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  child_en = '1;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready = '0;
  logic [31:0] out_data;
  logic [2:0]  out_sel;
  logic [2:0]  fifo_count;
  logic [15:0] dispatch_cnt;

  int   checks = 0;
  int   failures = 0;
  int   m_ptr = 0;
  exp_t sb[$];

  root500_child_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .child_en(child_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .fifo_count(fifo_count), .dispatch_cnt(dispatch_cnt)
  );

  always #5 clk = ~clk;

  function automatic int first_en(input int p, input logic [4:0] en);
    for (int k = 0; k < 5; k++) begin
      int j;
      j = (p + k) % 5;
      if (en[j[2:0]]) return j;
    end
    return p;
  endfunction

  // Every completed handshake is matched against the oldest expected dispatch.
  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < 5; i++)
        if (out_valid[i] & out_ready[i]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_dispatch child=%0d data=%h", i, out_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (i != e.ch || out_data !== e.d || int'(out_sel) != i) begin
              failures++;
              $display("FAIL dispatch got child=%0d sel=%0d data=%h want child=%0d data=%h",
                       i, out_sel, out_data, e.ch, e.d);
            end
          end
        end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_ptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] d);
    int ch;
    ch = first_en(m_ptr, child_en);
    in_valid = 1'b1;
    in_data = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{ch, d});
        m_ptr = (ch + 1) % 5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL push_timeout data=%h", d);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 5'b0 || fifo_count !== 3'd0 || dispatch_cnt !== 16'd0 ||
          out_sel !== 3'd0 || out_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_state rdy=%b ov=%b cnt=%0d dcnt=%0d sel=%0d data=%h want all zero",
                 in_ready, out_valid, fifo_count, dispatch_cnt, out_sel, out_data);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    do_reset();
    child_en = 5'b11111;
    out_ready = 5'b0;
    push(32'h11);
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b00001 || out_data !== 32'h11 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL latency ov=%b data=%h cnt=%0d want 00001 00000011 1", out_valid, out_data, fifo_count);
    end
    @(posedge clk); #1;
    out_ready = 5'b11111;
    drain();
  endtask

  task automatic test_rotation();
    do_reset();
    child_en = 5'b11111;
    out_ready = 5'b11111;
    for (int i = 0; i < 7; i++) push(32'hA0 + i);
    drain();
    checks++;
    if (dispatch_cnt !== 16'd7) begin
      failures++;
      $display("FAIL rotation_count got=%0d want 7", dispatch_cnt);
    end
  endtask

  task automatic test_skip();
    do_reset();
    child_en = 5'b10101;
    out_ready = 5'b11111;
    for (int i = 0; i < 4; i++) push(32'hB0 + i);
    drain();
    checks++;
    if (dispatch_cnt !== 16'd4) begin
      failures++;
      $display("FAIL skip_count got=%0d want 4", dispatch_cnt);
    end
  endtask

  task automatic test_full();
    do_reset();
    child_en = 5'b11111;
    out_ready = 5'b0;
    for (int i = 0; i < 4; i++) push(32'hE0 + i);
    in_valid = 1'b1;
    in_data = 32'hE4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4 || out_valid !== 5'b00001) begin
      failures++;
      $display("FAIL full_state rdy=%b cnt=%0d ov=%b want 0 4 00001", in_ready, fifo_count, out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL full_hold cnt=%0d want 4", fifo_count);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 5'b00001;
    @(posedge clk); #1;
    out_ready = 5'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3 || in_ready !== 1'b1 || out_valid !== 5'b0) begin
      failures++;
      $display("FAIL full_pop cnt=%0d rdy=%b ov=%b want 3 1 00000", fifo_count, in_ready, out_valid);
    end
    @(posedge clk); #1;
    out_ready = 5'b11111;
    drain();
    checks++;
    if (dispatch_cnt !== 16'd4) begin
      failures++;
      $display("FAIL full_count got=%0d want 4", dispatch_cnt);
    end
  endtask

  task automatic test_sticky();
    do_reset();
    child_en = 5'b11111;
    out_ready = 5'b00001;
    push(32'h10);
    drain();
    out_ready = 5'b0;
    push(32'h55);
    child_en = 5'b11101;
    in_valid = 1'b1;
    in_data = 32'h66;
    sb.push_back('{first_en(m_ptr, child_en), 32'h66});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 5'b00010 || out_data !== 32'h55) begin
        failures++;
        $display("FAIL sticky ov=%b data=%h want 00010 00000055", out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 5'b11111;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    child_en = 5'b01000;
    out_ready = 5'b0;
    push(32'h77);
    for (int n = 0; n < 10 && out_valid == 5'b0; n++) @(negedge clk);
    checks++;
    if (out_valid !== 5'b01000 || out_data !== 32'h77) begin
      failures++;
      $display("FAIL mid_offer ov=%b data=%h want 01000 00000077", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 5'b0 || out_data !== 32'd0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL async_reset ov=%b data=%h cnt=%0d want 0 0 0", out_valid, out_data, fifo_count);
    end
    sb.delete();
    m_ptr = 0;
    child_en = 5'b11111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_sel !== 3'd0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset sel=%0d cnt=%0d rdy=%b want 0 0 1", out_sel, fifo_count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rotation();
    test_skip();
    test_full();
    test_sticky();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
